led_sequencer: RTL and testbench
================================

LED_SEQUENCER -- requirements
Module: led_sequencer

Interface
REQ-001 Parameter WIDTH, default 6, number of LED outputs; legal range 2..32.
REQ-002 Parameter PRESCALE_BITS, default 23, width of the step-period prescaler; legal range 1..32.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 mode  input  2  pattern select: 00 Johnson trail, 01 bounce (single-hot), 10 binary count, 11 freeze.
REQ-006 dir  input  1  direction: 0 right/up-count, 1 left/down-count; ignored in bounce and freeze.
REQ-007 period  input  PRESCALE_BITS  step interval minus one, in clk cycles.
REQ-008 leds  output  WIDTH  current pattern, driven directly from a register.
REQ-009 step  output  1  one-cycle pulse on the cycle leds takes a new step value.

Function
REQ-010 Prescaler count SHALL increment each cycle; when count >= period, count SHALL return to 0 and an internal tick SHALL fire that cycle.
REQ-011 period = 0 SHALL tick every cycle; a period lowered below the current count SHALL tick on the next edge (>= compare, no wrap through 2^PRESCALE_BITS).
REQ-012 On tick in mode 00, dir=0: leds <= {~leds[0], leds[WIDTH-1:1]}; dir=1: leds <= {leds[WIDTH-2:0], ~leds[WIDTH-1]}; sequence period 2*WIDTH steps.
REQ-013 On tick in mode 01, the single hot bit SHALL move one position toward the MSB while the internal bounce flag is up, toward the LSB while down.
REQ-014 Bounce reversal: a step landing on bit WIDTH-1 SHALL set the flag down; a step landing on bit 0 SHALL set it up; endpoints are lit for exactly one step, never two.
REQ-015 On tick in mode 10, leds SHALL increment (dir=0) or decrement (dir=1) modulo 2^WIDTH.
REQ-016 Mode 11 SHALL hold leds, hold count at 0, and never assert step.
REQ-017 step SHALL be 1 exactly in the cycle following a tick in modes 00/01/10 (aligned with the leds update), else 0.
REQ-018 An internal registered mode_q SHALL track mode; when mode != mode_q on an edge: mode_q <= mode, count <= 0, step <= 0, leds <= seed of new mode, bounce flag <= up.
REQ-019 Seeds: mode 00 and 01 -> one-hot bit 0 (0...01); mode 10 -> all zeros; mode 11 -> current leds retained.
REQ-020 Mode change SHALL take priority over a coincident tick; no step is taken that cycle.
REQ-021 dir changes SHALL take effect at the next tick without reload.

Reset
REQ-022 While rst=1: count=0, leds=0...01, mode_q=00, bounce flag=up, step=0, asynchronously.
REQ-023 After rst release, if mode != 00, REQ-018 reload SHALL occur on the first edge.
REQ-024 Reset asserted mid-step SHALL abort the step; no partial pattern is ever visible.

Verification
REQ-025 WIDTH=6, mode=00, dir=0, period=3 from reset -> step every 4 cycles; leds 000001, 000000, 100000, 110000, ..., 111111, 011111, ..., 000000, 100000 (12-step period).
REQ-026 mode=01, period=0 -> leds 000001,000010,...,100000,010000,...,000001,000010; each endpoint lit for one step only.
REQ-027 mode=10, dir=1, period=0 from reload -> leds 000000, 111111, 111110; step high every cycle after the reload cycle.
REQ-028 period=100, count at 50, period changed to 10 -> tick on next edge, then every 11 cycles.
REQ-029 mode 00->11 mid-sequence -> leds frozen at current value, step stays 0; back to 01 -> leds 000001 with step=0 on reload cycle.
REQ-030 rst pulsed asynchronously between clock edges in mode 10 -> leds=000001 immediately, step=0; after release with mode=10, leds=000000 on first edge.

Source files
------------

// File: rtl/led_sequencer.sv
// -----------------------------------------------------------------------------
// led_sequencer
//
// Drives a bank of LEDs with one of four selectable patterns. The pattern
// advances once per prescaler tick.
//
// Patterns:
//   - Johnson trail, shifting right or left.
//   - Single-hot bounce between the two end LEDs.
//   - Binary up/down count.
//   - Freeze: the current LEDs are held.
//
// Parameters:
//   WIDTH         number of LED outputs (2..32)
//   PRESCALE_BITS width of the step-period prescaler (1..32)
//
// Ports:
//   clk     single clock; all state changes on its rising edge
//   rst     asynchronous, active-high reset
//   mode    pattern select
//             00 Johnson
//             01 bounce
//             10 binary count
//             11 freeze
//   dir     0 = right / count up, 1 = left / count down
//           (ignored in bounce and freeze)
//   period  step interval minus one, in clk cycles
//   leds    current pattern, straight from a register
//   step    one-cycle pulse, coincident with each new leds value
// -----------------------------------------------------------------------------
module led_sequencer #(
  parameter int WIDTH         = 6,
  parameter int PRESCALE_BITS = 23
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               mode,
  input  logic                     dir,
  input  logic [PRESCALE_BITS-1:0] period,
  output logic [WIDTH-1:0]         leds,
  output logic                     step
);

  localparam logic [1:0] MODE_JOHNSON = 2'b00;
  localparam logic [1:0] MODE_BOUNCE  = 2'b01;
  localparam logic [1:0] MODE_COUNT   = 2'b10;
  localparam logic [1:0] MODE_FREEZE  = 2'b11;

  localparam logic [WIDTH-1:0] LEDS_ONEHOT0 = WIDTH'(1);

  logic [PRESCALE_BITS-1:0] count_q, count_d;
  logic [WIDTH-1:0]         leds_q, leds_d;
  logic [1:0]               mode_q, mode_d;
  logic                     up_q, up_d;
  logic                     step_q, step_d;
  logic                     tick;

  // The >= compare (rather than ==) makes a period that is lowered below
  // the running count tick on the very next edge. It also prevents the
  // count from wrapping through the full 2^PRESCALE_BITS range.
  assign tick = (count_q >= period);

  always_comb begin
    count_d = count_q;
    leds_d  = leds_q;
    mode_d  = mode_q;
    up_d    = up_q;
    step_d  = 1'b0;

    if (mode != mode_q) begin
      // A mode change reloads the pattern and wins over a coincident tick.
      mode_d  = mode;
      count_d = '0;
      up_d    = 1'b1;
      unique case (mode)
        MODE_JOHNSON, MODE_BOUNCE: leds_d = LEDS_ONEHOT0;
        MODE_COUNT:                leds_d = '0;
        default:                   leds_d = leds_q;
      endcase
    end else if (mode_q == MODE_FREEZE) begin
      count_d = '0;
    end else if (tick) begin
      count_d = '0;
      step_d  = 1'b1;
      unique case (mode_q)
        MODE_JOHNSON: begin
          if (dir) leds_d = {leds_q[WIDTH-2:0], ~leds_q[WIDTH-1]};
          else     leds_d = {~leds_q[0], leds_q[WIDTH-1:1]};
        end
        MODE_BOUNCE: begin
          // The flag flips on the step that lands on an end LED. This
          // lights each end LED for exactly one step.
          if (up_q) begin
            leds_d = leds_q << 1;
            if (leds_d[WIDTH-1]) up_d = 1'b0;
          end else begin
            leds_d = leds_q >> 1;
            if (leds_d[0]) up_d = 1'b1;
          end
        end
        default: begin
          if (dir) leds_d = leds_q - WIDTH'(1);
          else     leds_d = leds_q + WIDTH'(1);
        end
      endcase
    end else begin
      count_d = count_q + PRESCALE_BITS'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      leds_q  <= LEDS_ONEHOT0;
      mode_q  <= MODE_JOHNSON;
      up_q    <= 1'b1;
      step_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      leds_q  <= leds_d;
      mode_q  <= mode_d;
      up_q    <= up_d;
      step_q  <= step_d;
    end
  end

  assign leds = leds_q;
  assign step = step_q;

endmodule

// File: tb/tb_led_sequencer.sv
module tb_led_sequencer;

  localparam int W  = 6;
  localparam int PB = 8;
  localparam int MASK = (1 << W) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    mode;
  logic          dir;
  logic [PB-1:0] period;
  logic [W-1:0]  leds;
  logic          step;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  // m_pos is the index of the lit LED while bouncing.
  int m_cnt, m_leds, m_mode, m_pos, m_step;
  bit m_up;

  led_sequencer #(.WIDTH(W), .PRESCALE_BITS(PB)) dut (
    .clk(clk), .rst(rst), .mode(mode), .dir(dir),
    .period(period), .leds(leds), .step(step)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_leds = 1; m_mode = 0; m_pos = 0; m_up = 1; m_step = 0;
  endtask

  // One rising edge of the specified behaviour, using the current inputs.
  task automatic model_edge();
    int p;
    p = int'(period);
    m_step = 0;
    if (int'(mode) != m_mode) begin
      m_mode = int'(mode);
      m_cnt  = 0;
      m_up   = 1;
      m_pos  = 0;
      if (m_mode == 0 || m_mode == 1) m_leds = 1;
      else if (m_mode == 2)           m_leds = 0;
    end else if (m_mode == 3) begin
      m_cnt = 0;
    end else if (m_cnt >= p) begin
      m_cnt  = 0;
      m_step = 1;
      case (m_mode)
        0: if (dir) m_leds = ((m_leds << 1) & MASK) | (((m_leds >> (W-1)) & 1) ^ 1);
           else     m_leds = (m_leds >> 1) | (((m_leds & 1) ^ 1) << (W-1));
        1: begin
             m_pos = m_up ? m_pos + 1 : m_pos - 1;
             if (m_pos == W-1) m_up = 0;
             if (m_pos == 0)   m_up = 1;
             m_leds = 1 << m_pos;
           end
        default: m_leds = (m_leds + (dir ? MASK : 1)) & MASK;
      endcase
    end else begin
      m_cnt++;
    end
  endtask

  // One clock cycle: advance the model, then compare just after the edge.
  task automatic cyc(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    chk({tag, ".leds"}, 32'(leds), 32'(m_leds));
    chk({tag, ".step"}, 32'(step), 32'(m_step));
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) cyc(tag);
  endtask

  logic [W-1:0] frozen;
  int gap;

  initial begin
    rst = 1'b1; mode = 2'b00; dir = 1'b0; period = 8'd3;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset.leds", 32'(leds), 32'h1);
    chk("reset.step", 32'(step), 32'h0);
    rst = 1'b0;

    // Johnson trail, period 3: a step every 4 cycles.
    run("john", 3);
    cyc("john");
    chk("john.s1", 32'(leds), 32'b000000);
    chk("john.p1", 32'(step), 32'h1);
    run("john", 4);
    chk("john.s2", 32'(leds), 32'b100000);
    run("john", 4);
    chk("john.s3", 32'(leds), 32'b110000);
    run("john", 48);
    dir = 1'b1;
    run("john_l", 30);

    // Bounce, period 0.
    mode = 2'b01; period = 8'd0;
    cyc("bnc_reload");
    chk("bnc.seed", 32'(leds), 32'h1);
    chk("bnc.seed_step", 32'(step), 32'h0);
    run("bnc", 5);
    chk("bnc.top", 32'(leds), 32'b100000);
    cyc("bnc");
    chk("bnc.after_top", 32'(leds), 32'b010000);
    run("bnc", 20);

    // Binary count down, period 0.
    mode = 2'b10; dir = 1'b1;
    cyc("cnt_reload");
    chk("cnt.seed", 32'(leds), 32'h0);
    cyc("cnt");
    chk("cnt.dn1", 32'(leds), 32'b111111);
    chk("cnt.dn1_step", 32'(step), 32'h1);
    cyc("cnt");
    chk("cnt.dn2", 32'(leds), 32'b111110);
    dir = 1'b0;
    run("cnt_up", 10);

    // Lowering period below the running count.
    mode = 2'b00; period = 8'd100;
    run("per", 51);
    period = 8'd10;
    cyc("per_drop");
    chk("per.drop_tick", 32'(step), 32'h1);
    gap = 0;
    do begin
      cyc("per_gap");
      gap++;
    end while (step !== 1'b1 && gap < 40);
    chk("per.gap", 32'(gap), 32'd11);

    // Freeze mid-sequence, then back to bounce.
    period = 8'd0;
    run("pre_frz", 3);
    frozen = leds;
    mode = 2'b11;
    run("frz", 6);
    chk("frz.hold", 32'(leds), 32'(frozen));
    mode = 2'b01;
    cyc("frz_exit");
    chk("frz.exit_leds", 32'(leds), 32'h1);
    chk("frz.exit_step", 32'(step), 32'h0);

    // Asynchronous reset between edges while counting.
    mode = 2'b10;
    run("arst_pre", 5);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("arst.leds", 32'(leds), 32'h1);
    chk("arst.step", 32'(step), 32'h0);
    rst = 1'b0;
    cyc("arst_post");
    chk("arst.reload", 32'(leds), 32'h0);

    // Randomized stimulus against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 29) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) dir  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 39) == 0)
        period = ($urandom_range(0, 4) == 0) ? PB'($urandom_range(0, 40))
                                             : PB'($urandom_range(0, 4));
      if ($urandom_range(0, 299) == 0) begin
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("rnd.arst", 32'(leds), 32'h1);
        rst = 1'b0;
      end
      cyc("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
